// File: rtl/lookahead_fifo.sv
// lookahead_fifo: first-word-fall-through FIFO exposing the head word and the
// word behind it, with occupancy count, programmable almost-full/almost-empty
// thresholds, synchronous flush and sticky overflow/underflow error flags.
module lookahead_fifo #(
   parameter int WIDTH      = 9,
   parameter int DEPTH_ADDR = 2,
   parameter int AF_LEVEL   = 3,
   parameter int AE_LEVEL   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_req_n,
   input  logic                  pop_req_n,
   input  logic                  flush,
   input  logic [WIDTH-1:0]      data_in,
   output logic [WIDTH-1:0]      data_out,
   output logic [WIDTH-1:0]      next_data_out,
   output logic                  empty,
   output logic                  full,
   output logic                  pre_empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [DEPTH_ADDR:0]   fill_cnt,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2 ** DEPTH_ADDR;
   localparam logic [DEPTH_ADDR:0] CNT_FULL = (DEPTH_ADDR + 1)'(DEPTH);
   localparam logic [DEPTH_ADDR:0] CNT_ONE  = (DEPTH_ADDR + 1)'(1);
   localparam logic [DEPTH_ADDR:0] CNT_AF   = (DEPTH_ADDR + 1)'(AF_LEVEL);
   localparam logic [DEPTH_ADDR:0] CNT_AE   = (DEPTH_ADDR + 1)'(AE_LEVEL);

   // Storage is deliberately left unreset; the pointers alone define validity.
   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_ADDR-1:0] wr_ptr;
   logic [DEPTH_ADDR-1:0] rd_ptr;
   logic [DEPTH_ADDR-1:0] rd_ptr_nxt;
   logic [DEPTH_ADDR:0]   cnt;

   logic push_req;
   logic pop_req;
   logic clear;
   logic pop_acc;
   logic push_acc;
   logic push_rej;
   logic pop_rej;

   assign push_req   = ~push_req_n;
   assign pop_req    = ~pop_req_n;
   assign clear      = rst | flush;
   assign rd_ptr_nxt = rd_ptr + 1'b1;

   // A pop frees a slot in the same cycle, so a push into a full FIFO is
   // accepted when paired with a pop. A pop on an empty FIFO never pairs with
   // the simultaneous push because the pushed word is not yet readable.
   assign pop_acc  = pop_req & ~empty & ~clear;
   assign push_acc = push_req & (~full | pop_acc) & ~clear;
   assign push_rej = push_req & full & ~pop_acc;
   assign pop_rej  = pop_req & empty;

   // Pointer, occupancy and sticky error flag update; reset and flush clear
   // everything except the storage array.
   always_ff @(posedge clk) begin
      if (clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + 1'b1;
         if (pop_acc)  rd_ptr <= rd_ptr_nxt;
         if (push_acc && !pop_acc)
            cnt <= cnt + 1'b1;
         else if (pop_acc && !push_acc)
            cnt <= cnt - 1'b1;
         if (push_rej) overflow  <= 1'b1;
         if (pop_rej)  underflow <= 1'b1;
      end
   end

   // Write port; a write into the head slot of an empty FIFO becomes visible
   // on data_out only after the edge because empty is still set this cycle.
   always_ff @(posedge clk) begin
      if (push_acc) mem[wr_ptr] <= data_in;
   end

   // Status flags decode from the registered count only, so they are clean
   // relative to clk and settle one edge after the causing request.
   always_comb begin
      fill_cnt      = cnt;
      empty         = (cnt == '0);
      full          = (cnt == CNT_FULL);
      pre_empty     = (cnt == CNT_ONE);
      almost_full   = (cnt >= CNT_AF);
      almost_empty  = (cnt <= CNT_AE);
      data_out      = empty ? '0 : mem[rd_ptr];
      next_data_out = (cnt > CNT_ONE) ? mem[rd_ptr_nxt] : '0;
   end

endmodule

// File: tb/tb_lookahead_fifo.sv
// Bench for lookahead_fifo: default instance driven with directed vectors,
// plus a WIDTH=16/DEPTH_ADDR=4 instance for threshold and random traffic.
module tb_lookahead_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b0;

   // Default-parameter instance
   logic        push_n = 1'b1, pop_n = 1'b1, flush = 1'b0;
   logic [8:0]  din = '0;
   logic [8:0]  dout, ndout;
   logic        empty, full, pre_empty, af, ae, ovf, udf;
   logic [2:0]  fill;

   // Swept-parameter instance
   logic        push2_n = 1'b1, pop2_n = 1'b1, flush2 = 1'b0;
   logic [15:0] din2 = '0;
   logic [15:0] dout2, ndout2;
   logic        empty2, full2, pre_empty2, af2, ae2, ovf2, udf2;
   logic [4:0]  fill2;

   lookahead_fifo u_dut (
      .clk(clk), .rst(rst), .push_req_n(push_n), .pop_req_n(pop_n),
      .flush(flush), .data_in(din), .data_out(dout), .next_data_out(ndout),
      .empty(empty), .full(full), .pre_empty(pre_empty), .almost_full(af),
      .almost_empty(ae), .fill_cnt(fill), .overflow(ovf), .underflow(udf)
   );

   lookahead_fifo #(.WIDTH(16), .DEPTH_ADDR(4), .AF_LEVEL(12), .AE_LEVEL(3)) u_dut2 (
      .clk(clk), .rst(rst), .push_req_n(push2_n), .pop_req_n(pop2_n),
      .flush(flush2), .data_in(din2), .data_out(dout2), .next_data_out(ndout2),
      .empty(empty2), .full(full2), .pre_empty(pre_empty2), .almost_full(af2),
      .almost_empty(ae2), .fill_cnt(fill2), .overflow(ovf2), .underflow(udf2)
   );

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   logic [8:0]  q1[$];
   logic [15:0] q2[$];
   int cnt1 = 0;
   int cnt2 = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", nm, act, exp);
      end
   endtask

   // Monitor for the default instance: compares visible words and flags
   // against the scoreboard, and retires the head when a pop is taken.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("m1_fill",  32'(fill), 32'(q1.size()));
         chk("m1_empty", 32'(empty), 32'(q1.size() == 0));
         chk("m1_full",  32'(full), 32'(q1.size() == 4));
         chk("m1_pre_empty", 32'(pre_empty), 32'(q1.size() == 1));
         chk("m1_af", 32'(af), 32'(q1.size() >= 3));
         chk("m1_ae", 32'(ae), 32'(q1.size() <= 1));
         chk("m1_head", 32'(dout), (q1.size() > 0) ? 32'(q1[0]) : 32'd0);
         chk("m1_next", 32'(ndout), (q1.size() > 1) ? 32'(q1[1]) : 32'd0);
         if (!rst && !flush && !pop_n && q1.size() > 0) void'(q1.pop_front());
      end
   end

   // Monitor for the swept instance.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("m2_fill",  32'(fill2), 32'(q2.size()));
         chk("m2_empty", 32'(empty2), 32'(q2.size() == 0));
         chk("m2_full",  32'(full2), 32'(q2.size() == 16));
         chk("m2_pre_empty", 32'(pre_empty2), 32'(q2.size() == 1));
         chk("m2_af", 32'(af2), 32'(q2.size() >= 12));
         chk("m2_ae", 32'(ae2), 32'(q2.size() <= 3));
         chk("m2_head", 32'(dout2), (q2.size() > 0) ? 32'(q2[0]) : 32'd0);
         chk("m2_next", 32'(ndout2), (q2.size() > 1) ? 32'(q2[1]) : 32'd0);
         if (!rst && !flush2 && !pop2_n && q2.size() > 0) void'(q2.pop_front());
      end
   end

   // One cycle on the default instance; expected words enter the scoreboard
   // when the FIFO is expected to accept them.
   task automatic step1(input bit p, input bit q, input logic [8:0] d,
                        input bit fl = 1'b0, input bit r = 1'b0);
      bit pop_ok, push_ok;
      push_n = ~p; pop_n = ~q; din = d; flush = fl; rst = r;
      @(posedge clk);
      #1;
      push_n = 1'b1; pop_n = 1'b1; flush = 1'b0; rst = 1'b0;
      if (r || fl) begin
         q1.delete(); cnt1 = 0;
         if (r) begin q2.delete(); cnt2 = 0; end
      end else begin
         pop_ok  = q && (cnt1 != 0);
         push_ok = p && ((cnt1 != 4) || pop_ok);
         if (push_ok) q1.push_back(d);
         cnt1 = cnt1 + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
      end
   endtask

   task automatic step2(input bit p, input bit q, input logic [15:0] d);
      bit pop_ok, push_ok;
      push2_n = ~p; pop2_n = ~q; din2 = d;
      @(posedge clk);
      #1;
      push2_n = 1'b1; pop2_n = 1'b1;
      pop_ok  = q && (cnt2 != 0);
      push_ok = p && ((cnt2 != 16) || pop_ok);
      if (push_ok) q2.push_back(d);
      cnt2 = cnt2 + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
   endtask

   initial begin
      // Reset state
      step1(0, 0, '0, 0, 1);
      mon_en = 1'b1;
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_pre_empty", 32'(pre_empty), 0);
      chk("rst_ae", 32'(ae), 1);
      chk("rst_af", 32'(af), 0);
      chk("rst_fill", 32'(fill), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_udf", 32'(udf), 0);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_ndout", 32'(ndout), 0);

      // Three pushes
      step1(1, 0, 9'h011);
      chk("p1_dout", 32'(dout), 32'h011);
      step1(1, 0, 9'h022);
      step1(1, 0, 9'h033);
      chk("p3_fill", 32'(fill), 3);
      chk("p3_dout", 32'(dout), 32'h011);
      chk("p3_ndout", 32'(ndout), 32'h022);
      chk("p3_af", 32'(af), 1);
      chk("p3_empty", 32'(empty), 0);
      chk("p3_full", 32'(full), 0);

      // Fill, overflow, drain
      step1(0, 0, '0, 0, 1);
      for (int i = 1; i <= 4; i++) step1(1, 0, 9'(9'h100 + i));
      chk("fill4_full", 32'(full), 1);
      chk("fill4_cnt", 32'(fill), 4);
      step1(1, 0, 9'h1FF);
      chk("ovf_set", 32'(ovf), 1);
      chk("ovf_cnt", 32'(fill), 4);
      chk("ovf_head", 32'(dout), 32'h101);
      step1(0, 1, '0);
      chk("drain1_dout", 32'(dout), 32'h102);
      step1(0, 1, '0);
      chk("drain2_dout", 32'(dout), 32'h103);
      step1(0, 1, '0);
      chk("drain3_dout", 32'(dout), 32'h104);
      step1(0, 1, '0);
      chk("drain_empty", 32'(empty), 1);
      chk("drain_dout", 32'(dout), 0);
      chk("ovf_sticky", 32'(ovf), 1);

      // Wrap-around at occupancy 2
      step1(0, 0, '0, 1, 0);
      step1(1, 0, 9'h0C0);
      step1(1, 0, 9'h0C1);
      for (int i = 2; i < 10; i++) begin
         step1(1, 1, 9'(9'h0C0 + i));
         chk("wrap_dout", 32'(dout), 32'(9'h0C0 + i - 1));
      end
      step1(0, 1, '0);
      chk("wrap_pre_empty", 32'(pre_empty), 1);
      chk("wrap_last", 32'(dout), 32'h0C9);
      step1(0, 1, '0);
      chk("wrap_done_empty", 32'(empty), 1);

      // Simultaneous push+pop when full
      for (int i = 1; i <= 4; i++) step1(1, 0, 9'(9'h0A0 + i));
      step1(1, 1, 9'h0AA);
      chk("pp_full_cnt", 32'(fill), 4);
      chk("pp_full_head", 32'(dout), 32'h0A2);
      chk("pp_full_ovf", 32'(ovf), 0);
      for (int i = 0; i < 3; i++) step1(0, 1, '0);
      chk("pp_full_lastword", 32'(dout), 32'h0AA);
      step1(0, 1, '0);

      // Simultaneous push+pop when empty
      step1(1, 1, 9'h055);
      chk("pp_empty_cnt", 32'(fill), 1);
      chk("pp_empty_dout", 32'(dout), 32'h055);
      chk("pp_empty_udf", 32'(udf), 1);

      // Flush with push in the same cycle
      step1(1, 0, 9'h061);
      step1(1, 0, 9'h062);
      chk("pre_flush_cnt", 32'(fill), 3);
      step1(1, 0, 9'h077, 1, 0);
      chk("flush_cnt", 32'(fill), 0);
      chk("flush_empty", 32'(empty), 1);
      chk("flush_ovf", 32'(ovf), 0);
      chk("flush_udf", 32'(udf), 0);
      step1(0, 0, '0);
      chk("flush_discard", 32'(fill), 0);

      // Reset mid-stream with push
      step1(0, 1, '0);
      chk("udf_again", 32'(udf), 1);
      for (int i = 1; i <= 3; i++) step1(1, 0, 9'(9'h070 + i));
      step1(1, 0, 9'h07F, 0, 1);
      chk("rst_mid_cnt", 32'(fill), 0);
      chk("rst_mid_empty", 32'(empty), 1);
      chk("rst_mid_ovf", 32'(ovf), 0);
      chk("rst_mid_udf", 32'(udf), 0);
      chk("rst_mid_dout", 32'(dout), 0);

      // Swept instance: fill to 16 through the thresholds, overflow, drain
      for (int i = 0; i < 16; i++) begin
         step2(1, 0, 16'(16'h1000 + i));
         if (i == 10) chk("sw_af_low", 32'(af2), 0);
         if (i == 11) chk("sw_af_rise", 32'(af2), 1);
         if (i == 2)  chk("sw_ae_at3", 32'(ae2), 1);
         if (i == 3)  chk("sw_ae_at4", 32'(ae2), 0);
      end
      chk("sw_full", 32'(full2), 1);
      chk("sw_cnt16", 32'(fill2), 16);
      step2(1, 0, 16'hDEAD);
      chk("sw_ovf", 32'(ovf2), 1);
      for (int i = 0; i < 16; i++) step2(0, 1, '0);
      chk("sw_drained", 32'(empty2), 1);

      // Swept instance: random traffic against the scoreboard
      for (int i = 0; i < 400; i++)
         step2(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 16'($urandom));

      step1(0, 0, '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
